// File: rtl/regfile_dump.sv
// Sequential read-out engine: walks register-file addresses 0..LAST_ADDR and
// streams each captured value with its index over a valid/ready interface.
module regfile_dump #(
  parameter int unsigned LAST_ADDR = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        skip_zero,
  output logic [4:0]  rf_a,
  input  logic [31:0] rf_rd,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST = 5'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic        skip_q, skip_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  daddr_q, daddr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      skip_q  <= 1'b0;
      data_q  <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      skip_q  <= skip_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    skip_d  = skip_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          skip_d  = skip_zero;
          state_d = READ;
        end
      end
      READ: begin
        data_d  = rf_rd;
        daddr_d = addr_q;
        if (!skip_q || (rf_rd != 32'd0)) begin
          state_d = HOLD;
        end else if (addr_q == LAST) begin
          state_d = DONE;
        end else begin
          addr_d = addr_q + 5'd1;
        end
      end
      HOLD: begin
        // The LAST compare precedes any increment, so addr never wraps.
        if (dump_ready) begin
          if (addr_q == LAST) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 5'd1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_a       = addr_q;
  assign dump_addr  = daddr_q;
  assign dump_data  = data_q;
  assign dump_valid = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule
